// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the receiver, transmitter and baud generator.
// Optional parity support is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the rx line plus a tick-rate previous sample.
// Both reset to 1 so an idle-high line never looks like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_rx,
  output logic o_line,
  output logic o_prev
);

  logic r_meta;
  logic r_line;
  logic r_prev;

  // Resynchronise every clk; remember the line value seen at the last tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_line <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_line <= r_meta;
      if (i_tick)
        r_prev <= r_line;
    end
  end

  assign o_line = r_line;
  assign o_prev = r_prev;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: start detect, mid-bit sampling, word + error flags output.
// Define UART_RX_PARITY_EN to receive a parity bit between data and stop.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_tick,
  input  logic                 rx_in,
  input  logic                 par_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

  logic w_line;
  logic w_prev;

  rx_state_t            r_state;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_perr;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bit;
`else
  logic                 w_unused;
  assign w_unused = par_odd;
`endif

  uart_rx_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .i_tick (rx_tick),
    .i_rx   (rx_in),
    .o_line (w_line),
    .o_prev (w_prev)
  );

  // Frame FSM: counters advance only on ticks; rx_valid is a 1-clk strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_perr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit  <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (rx_tick) begin
        unique case (r_state)
          IDLE: begin
            if (w_prev && !w_line) begin
              r_state    <= START;
              r_tick_cnt <= '0;
            end
          end
          START: begin
            if (r_tick_cnt == HALF) begin
              if (w_line) begin
                r_state <= IDLE;
              end else begin
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
                r_state    <= DATA;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
          DATA: begin
            if (r_tick_cnt == LAST) begin
              r_tick_cnt <= '0;
              r_shift    <= {w_line, r_shift[DATA_BITS-1:1]};
              r_bit_cnt  <= r_bit_cnt + BW'(1);
              if (r_bit_cnt == BLAST) begin
`ifdef UART_RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (r_tick_cnt == LAST) begin
              r_tick_cnt <= '0;
              r_par_bit  <= w_line;
              r_state    <= STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
`endif
          STOP: begin
            if (r_tick_cnt == LAST) begin
              r_tick_cnt <= '0;
              r_state    <= IDLE;
              r_data     <= r_shift;
              r_valid    <= 1'b1;
              r_ferr     <= ~w_line;
`ifdef UART_RX_PARITY_EN
              r_perr     <= r_par_bit ^ (^r_shift) ^ par_odd;
`else
              r_perr     <= 1'b0;
`endif
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign frame_err  = r_ferr;
  assign parity_err = r_perr;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: frames queue expectations, a monitor checks strobes.
// Parity scenarios run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_tick = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_odd = PAR_EVEN;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int   n_tests = 0;
  int   n_fail = 0;
  int   div = 1;
  exp_t q[$];

  uart_rx_frame #(
    .DATA_BITS  (8),
    .OVERSAMPLE (OS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_tick    (rx_tick),
    .rx_in      (rx_in),
    .par_odd    (par_odd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      rx_tick = (c == 0);
      c = (c + 1 >= div) ? 0 : c + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: got data %0h expected no strobe",
                   rx_data);
        end else begin
          e = q.pop_front();
          chk("rx_data", {24'd0, rx_data}, {24'd0, e.d});
          chk("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
          chk("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
          chk("busy_at_strobe", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (OS * div) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic stp, input logic fe,
                            input logic pe);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    e.pe = pe;
    q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++)
      send_bit(d[i]);
    if (PEN)
      send_bit(p);
    send_bit(stp);
  endtask

  task automatic idle(input int nbits);
    for (int i = 0; i < nbits; i++)
      send_bit(1'b1);
  endtask

  task automatic drain;
    int k;
    k = 0;
    while (q.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("drain_queue", q.size(), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data", {24'd0, rx_data}, 32'h0);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_perr", {31'd0, parity_err}, 32'd0);

    for (int pass = 0; pass < 2; pass++) begin
      div = (pass == 0) ? 1 : 3;
      idle(2);

      send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      drain();
      chk("busy_after_A5", {31'd0, busy}, 32'd0);

      rx_in = 1'b0;
      repeat (4 * div) @(negedge clk);
      chk("busy_false_start", {31'd0, busy}, 32'd1);
      rx_in = 1'b1;
      idle(2);
      chk("busy_after_false", {31'd0, busy}, 32'd0);

      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3 * OS * div) @(negedge clk);
      drain();
      chk("busy_line_low", {31'd0, busy}, 32'd0);
      idle(2);

`ifdef UART_RX_PARITY_EN
      par_odd = PAR_EVEN;
      send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(1);
      send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b1);
      idle(1);
      par_odd = PAR_ODD;
      send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      drain();
      par_odd = PAR_EVEN;
`endif

      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      chk("busy_mid_data", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      rx_in = 1'b1;
      @(negedge clk);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
      chk("rst_mid_data", {24'd0, rx_data}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      idle(2);
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      drain();
      chk("busy_after_5A", {31'd0, busy}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
